// File: rtl/controle_comandos_peso.sv
// Command sequencer: parses ASCII weight commands from the UART receiver,
// validates them and atomically commits limits/current weight plus range selector.
module controle_comandos_peso #(
  parameter int TIMEOUT_CLKS = 43400,
  parameter int DEF_MIN      = 0,
  parameter int DEF_MAX      = 99
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] rx_dado,
  input  logic       rx_pronto,
  output logic [6:0] peso_min,
  output logic [6:0] peso_max,
  output logic [6:0] peso_atual,
  output logic [1:0] faixa,
  output logic       atualizado,
  output logic       erro,
  output logic       ocupado,
  output logic [2:0] estado_db
);

  typedef enum logic [2:0] {
    OCIOSO        = 3'd0,
    ESPERA_DIGITO = 3'd1,
    VALIDA        = 3'd2,
    APLICA        = 3'd3,
    ERRO          = 3'd4
  } estado_t;

  localparam int         TW        = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [6:0] MIN_RST   = 7'(DEF_MIN);
  localparam logic [6:0] MAX_RST   = 7'(DEF_MAX);
  localparam logic [1:0] FAIXA_RST = (DEF_MIN == 0) ? 2'b01 : 2'b00;
  // Idle count at which the next silent cycle reaches TIMEOUT_CLKS-1.
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 2);

  estado_t       state;
  logic          cmd_um;
  logic [2:0]    pos;
  logic [6:0]    sh_min;
  logic [6:0]    sh_max;
  logic [6:0]    sh_atual;
  logic [TW-1:0] timeout_cnt;

  logic       is_digit;
  logic [6:0] dig;
  logic [6:0] new_min;
  logic [6:0] new_max;
  logic [6:0] new_atual;
  logic [1:0] new_faixa;

  // Digit positions 0..5 map to min/max/atual tens/units; command '1' starts at 4.
  function automatic logic [6:0] acumula(input logic [6:0] campo, input logic unidade,
                                          input logic [6:0] dv);
    acumula = unidade ? (campo + dv) : ((dv << 3) + (dv << 1));
  endfunction

  always_comb begin
    is_digit  = (rx_dado >= 8'h30) && (rx_dado <= 8'h39);
    dig       = {3'b000, rx_dado[3:0]};
    new_min   = cmd_um ? peso_min : sh_min;
    new_max   = cmd_um ? peso_max : sh_max;
    new_atual = sh_atual;
    if (new_atual < new_min)
      new_faixa = 2'b00;
    else if (new_atual > new_max)
      new_faixa = 2'b10;
    else
      new_faixa = 2'b01;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= OCIOSO;
      cmd_um      <= 1'b0;
      pos         <= 3'd0;
      sh_min      <= 7'd0;
      sh_max      <= 7'd0;
      sh_atual    <= 7'd0;
      timeout_cnt <= '0;
      peso_min    <= MIN_RST;
      peso_max    <= MAX_RST;
      peso_atual  <= 7'd0;
      faixa       <= FAIXA_RST;
    end else begin
      case (state)
        OCIOSO: begin
          timeout_cnt <= '0;
          if (rx_pronto) begin
            if (rx_dado == 8'h30) begin
              cmd_um <= 1'b0;
              pos    <= 3'd0;
              state  <= ESPERA_DIGITO;
            end else if (rx_dado == 8'h31) begin
              cmd_um <= 1'b1;
              pos    <= 3'd4;
              state  <= ESPERA_DIGITO;
            end else begin
              state <= ERRO;
            end
          end
        end
        ESPERA_DIGITO: begin
          if (rx_pronto) begin
            timeout_cnt <= '0;
            if (!is_digit) begin
              state <= ERRO;
            end else begin
              case (pos[2:1])
                2'd0:    sh_min   <= acumula(sh_min, pos[0], dig);
                2'd1:    sh_max   <= acumula(sh_max, pos[0], dig);
                default: sh_atual <= acumula(sh_atual, pos[0], dig);
              endcase
              if (pos == 3'd5)
                state <= VALIDA;
              else
                pos <= pos + 3'd1;
            end
          end else if (timeout_cnt == TO_LAST) begin
            state <= ERRO;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        VALIDA: begin
          if (!cmd_um && (sh_min > sh_max)) begin
            state <= ERRO;
          end else begin
            peso_min   <= new_min;
            peso_max   <= new_max;
            peso_atual <= new_atual;
            faixa      <= new_faixa;
            state      <= APLICA;
          end
        end
        APLICA: begin
          pos   <= 3'd0;
          state <= OCIOSO;
        end
        ERRO: begin
          sh_min      <= 7'd0;
          sh_max      <= 7'd0;
          sh_atual    <= 7'd0;
          pos         <= 3'd0;
          timeout_cnt <= '0;
          state       <= OCIOSO;
        end
        default: state <= OCIOSO;
      endcase
    end
  end

  assign atualizado = (state == APLICA);
  assign erro       = (state == ERRO);
  assign ocupado    = (state != OCIOSO);
  assign estado_db  = state;

endmodule

// File: tb/tb_controle_comandos_peso.sv
// Scoreboard bench for controle_comandos_peso: expected commit/error events are
// queued as commands are driven and checked when atualizado/erro pulse.
module tb_controle_comandos_peso;

  localparam int TO   = 43400;
  localparam int DMIN = 0;
  localparam int DMAX = 99;
  localparam int GAP  = 20;

  logic       clock;
  logic       reset;
  logic [7:0] rx_dado;
  logic       rx_pronto;
  logic [6:0] peso_min;
  logic [6:0] peso_max;
  logic [6:0] peso_atual;
  logic [1:0] faixa;
  logic       atualizado;
  logic       erro;
  logic       ocupado;
  logic [2:0] estado_db;

  controle_comandos_peso #(
    .TIMEOUT_CLKS(TO),
    .DEF_MIN(DMIN),
    .DEF_MAX(DMAX)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rx_dado(rx_dado),
    .rx_pronto(rx_pronto),
    .peso_min(peso_min),
    .peso_max(peso_max),
    .peso_atual(peso_atual),
    .faixa(faixa),
    .atualizado(atualizado),
    .erro(erro),
    .ocupado(ocupado),
    .estado_db(estado_db)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  typedef struct {
    int is_err;
    int mn;
    int mx;
    int at;
    int fx;
  } evt_t;

  evt_t sb[$];
  int compared   = 0;
  int mismatched = 0;
  int m_min;
  int m_max;
  int m_atual;

  function automatic int faixa_of(input int a, input int mn, input int mx);
    if (a < mn) return 0;
    if (a > mx) return 2;
    return 1;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clock);
    rx_dado   = b;
    rx_pronto = 1'b1;
    @(negedge clock);
    rx_pronto = 1'b0;
    repeat (GAP) @(negedge clock);
  endtask

  task automatic expect_commit(input int mn, input int mx, input int at);
    evt_t e;
    m_min   = mn;
    m_max   = mx;
    m_atual = at;
    e.is_err = 0;
    e.mn = mn;
    e.mx = mx;
    e.at = at;
    e.fx = faixa_of(at, mn, mx);
    sb.push_back(e);
  endtask

  task automatic expect_error();
    evt_t e;
    e.is_err = 1;
    e.mn = m_min;
    e.mx = m_max;
    e.at = m_atual;
    e.fx = faixa_of(m_atual, m_min, m_max);
    sb.push_back(e);
  endtask

  task automatic send_pair(input int v);
    applyStimulus(8'(8'h30 + v / 10));
    applyStimulus(8'(8'h30 + v % 10));
  endtask

  task automatic send_cmd0(input int mn, input int mx, input int at);
    if (mn <= mx) expect_commit(mn, mx, at);
    else expect_error();
    applyStimulus(8'h30);
    send_pair(mn);
    send_pair(mx);
    send_pair(at);
  endtask

  task automatic send_cmd1(input int at);
    expect_commit(m_min, m_max, at);
    applyStimulus(8'h31);
    send_pair(at);
  endtask

  task automatic drain();
    repeat (8) @(negedge clock);
    checkOutput("sb_empty", sb.size(), 0);
  endtask

  task automatic check_reset_values();
    checkOutput("rst_min", peso_min, DMIN);
    checkOutput("rst_max", peso_max, DMAX);
    checkOutput("rst_atual", peso_atual, 0);
    checkOutput("rst_faixa", faixa, (DMIN == 0) ? 1 : 0);
    checkOutput("rst_ocupado", ocupado, 0);
    checkOutput("rst_estado", estado_db, 0);
    checkOutput("rst_atualizado", atualizado, 0);
    checkOutput("rst_erro", erro, 0);
  endtask

  // Event monitor: every pulse must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clock);
      if (atualizado || erro) begin
        checkOutput("excl", int'(atualizado && erro), 0);
        if (sb.size() == 0) begin
          checkOutput("unexpected_evt", 1, 0);
        end else begin
          evt_t e;
          e = sb.pop_front();
          checkOutput("evt_kind", int'(erro), e.is_err);
          checkOutput("peso_min", peso_min, e.mn);
          checkOutput("peso_max", peso_max, e.mx);
          checkOutput("peso_atual", peso_atual, e.at);
          checkOutput("faixa", faixa, e.fx);
        end
      end
    end
  end

  initial begin
    int cnt;
    int ocup_mid;
    rx_dado   = 8'h00;
    rx_pronto = 1'b0;
    reset     = 1'b1;
    #5 reset  = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_values();
    reset = 1'b1;
    m_min   = DMIN;
    m_max   = DMAX;
    m_atual = 0;
    repeat (2) @(negedge clock);

    send_cmd0(10, 20, 15);
    drain();
    checkOutput("c1_faixa", faixa, 1);

    send_cmd1(25);
    send_cmd1(5);
    drain();

    send_cmd0(30, 10, 5);
    drain();

    expect_error();
    applyStimulus(8'h30);
    applyStimulus(8'h31);
    applyStimulus(8'h41);
    drain();
    checkOutput("bad_digit_estado", estado_db, 0);
    send_cmd1(12);
    drain();

    // Timeout: count edges from the edge sampling the 2nd byte until erro.
    expect_error();
    applyStimulus(8'h30);
    @(negedge clock);
    rx_dado   = 8'h31;
    rx_pronto = 1'b1;
    @(posedge clock);
    #1 rx_pronto = 1'b0;
    cnt = 0;
    ocup_mid = 0;
    while (cnt < TO + 20) begin
      @(posedge clock);
      cnt++;
      #1;
      if (cnt == 100) ocup_mid = int'(ocupado);
      if (erro) break;
    end
    checkOutput("timeout_lat", cnt, TO - 1);
    checkOutput("timeout_ocupado_mid", ocup_mid, 1);
    @(posedge clock);
    #1 checkOutput("timeout_ocupado_fall", ocupado, 0);
    drain();

    expect_error();
    applyStimulus(8'h7A);
    drain();

    send_cmd0(42, 42, 42);
    send_cmd1(41);
    send_cmd1(43);
    send_cmd0(0, 99, 99);
    drain();
    for (int i = 0; i < 4; i++) send_cmd1(int'($urandom_range(0, 99)));
    drain();

    // Reset in the middle of a '0' command after four digits.
    applyStimulus(8'h30);
    applyStimulus(8'h32);
    applyStimulus(8'h33);
    applyStimulus(8'h34);
    applyStimulus(8'h35);
    #3 reset = 1'b0;
    #1 check_reset_values();
    m_min   = DMIN;
    m_max   = DMAX;
    m_atual = 0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      expect_error();
      applyStimulus(8'(8'h36 + i));
    end
    drain();
    checkOutput("post_rst_atual", peso_atual, 0);
    checkOutput("post_rst_max", peso_max, DMAX);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
